// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM state type and default bus widths
// used by the requester, the register slaves and the address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_AWIDTH = 4;
    localparam int APB_DWIDTH = 8;

endpackage

// File: rtl/apb_requester.sv
// APB requester: one valid/ready command becomes a SETUP/ACCESS transfer and a one-cycle response.
// Latency: response 3 cycles after accept plus one per PREADY-low ACCESS cycle; 3-cycle minimum spacing.
// Backpressure: cmd_ready only in IDLE; no response backpressure. APB_REQ_TIMEOUT_EN adds an ACCESS timeout.
module apb_requester
    import apb_pkg::*;
#(
    parameter int AWIDTH         = APB_AWIDTH,
    parameter int DWIDTH         = APB_DWIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    // Counts PREADY-low ACCESS cycles; the limit is hit on the cycle whose increment would reach it.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !PREADY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign cmd_ready = (state_q == IDLE) && !PRESET;

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end
`ifdef APB_REQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // Bus strobes are registered from the next state so they change cleanly on the edge.
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: table of transfers plus hand-written reset and timeout sequences.
module tb_apb_requester;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    apb_requester #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          b2b;
    } vec_t;

    vec_t vecs[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge where rsp_valid must be high.
    task automatic xfer(input vec_t v);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.write);
        if (v.write) chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_cmd_ready", cmd_ready, 0);
        // Junk in SETUP must not complete the transfer.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 8'hFF;
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge PCLK);
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, v.addr);
            chk("access_pwrite", PWRITE, v.write);
            chk("access_no_rsp", rsp_valid, 0);
            if (k == v.waits) begin
                PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
            end else begin
                PREADY = 1'b0; PRDATA = 8'hFF; PSLVERR = 1'b1;
            end
        end
        @(negedge PCLK);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_psel_low", PSEL, 0);
        chk("rsp_penable_low", PENABLE, 0);
        chk("rsp_cmd_ready", cmd_ready, 1);
        chk("rsp_paddr_held", PADDR, v.addr);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_psel"}, PSEL, 0);
        chk({tag, "_penable"}, PENABLE, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        vec_t v;
        //         wr    addr   wdata  wt prdata slverr exp_rd exp_err b2b
        vecs[0] = '{1'b1, 4'h2, 8'hA5, 0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'h6, 8'h00, 3, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'hF, 8'h00, 0, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 4'h0, 8'h11, 0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 4'h1, 8'h22, 0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 4'h2, 8'h33, 0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'h99;
        PRDATA = 8'h00; PREADY = 1'b1; PSLVERR = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("reset_cmd_ready", cmd_ready, 0);
        outputs_zero("reset");
        chk("reset_pwrite", PWRITE, 0);
        chk("reset_paddr", PADDR, 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        PRESET = 1'b0; cmd_valid = 1'b0; PREADY = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i]);
            if (!vecs[i].b2b) begin
                @(negedge PCLK);
                chk("rsp_one_cycle", rsp_valid, 0);
            end
        end

        // Reset during ACCESS with the slave stalled.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h9;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_access_penable", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        outputs_zero("mid_reset");
        chk("mid_reset_cmd_ready", cmd_ready, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        outputs_zero("post_reset");
        v = '{1'b0, 4'h4, 8'h00, 1, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0};
        xfer(v);
        @(negedge PCLK);

        // Slave never raises PREADY.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h7;
        PREADY = 1'b0; PRDATA = 8'hFF; PSLVERR = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            @(negedge PCLK);
            chk("to_access_penable", PENABLE, 1);
            chk("to_access_no_rsp", rsp_valid, 0);
        end
        @(negedge PCLK);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_psel_low", PSEL, 0);
        chk("to_penable_low", PENABLE, 0);
`else
        begin
            int bad = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge PCLK);
                if (!(PSEL === 1'b1 && PENABLE === 1'b1 && rsp_valid === 1'b0)) bad++;
            end
            chk("hang_access_cycles_left", bad, 0);
            chk("hang_penable", PENABLE, 1);
            chk("hang_cmd_ready", cmd_ready, 0);
        end
`endif
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
